// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared constants, types and helpers for the LED PWM generator.
//   DUTY_MAX   : largest legal duty in percent
//   N_SLOTS    : duty slots per PWM period
//   duty_t     : 7-bit unsigned duty / slot value (0..100)
//   clamp_duty : saturates a signed 32-bit request into 0..DUTY_MAX
package pwm_pkg;

  localparam int DUTY_MAX = 100;
  localparam int N_SLOTS  = 100;

  typedef logic [6:0] duty_t;

  // Negative requests mean "off", anything above 100 % means "full on".
  function automatic duty_t clamp_duty(input logic signed [31:0] d);
    if (d < 0)
      return '0;
    else if (d > DUTY_MAX)
      return duty_t'(DUTY_MAX);
    else
      return duty_t'(d[6:0]);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen -- prescaler producing one tick every PRESCALE clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous hold of the count at zero (no tick while high)
//   tick  : high on the last clock of each prescale interval
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 120
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int          CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pre_cnt <= '0;
    else if (clear || pre_cnt == LAST)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  // Gated by clear so a PRESCALE of 1 does not tick while the block is held.
  assign tick = !clear && (pre_cnt == LAST);

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen -- 100-slot LED PWM generator with clamped, shadowed duty.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   en           : run enable; low holds counters at zero and output inactive
//   duty         : requested duty in percent (signed, clamped to 0..100)
//   pwm_out      : registered LED drive (polarity set by ACTIVE_LOW)
//   period_start : one-clock pulse aligned with the first slot-0 output clock
//   duty_active  : shadow duty currently applied
// Build option: define PWM_SHADOW_EN to update the shadow only at period
// boundaries; otherwise the shadow follows the clamped duty every clock.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 120,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [31:0] duty,
  output logic               pwm_out,
  output logic               period_start,
  output logic [6:0]         duty_active
);

  localparam logic  ON        = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic  OFF       = ~ON;
  localparam duty_t SLOT_LAST = duty_t'(N_SLOTS - 1);

  logic  tick;
  logic  wrap;
  logic  load;
  logic  at_start;
  duty_t slot;
  duty_t shadow;
  duty_t duty_c;

  pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!en),
    .tick  (tick)
  );

  assign duty_c = clamp_duty(duty);
  assign wrap   = tick && (slot == SLOT_LAST);

`ifdef PWM_SHADOW_EN
  // Period-aligned load; while stopped the shadow tracks the input so a
  // restart begins with the current request.
  assign load = !en || wrap;
`else
  assign load = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot <= '0;
    else if (!en)
      slot <= '0;
    else if (tick)
      slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (load)
      shadow <= duty_c;
  end

  // at_start marks that the counters now sit at (0,0) -- the first clock of a
  // period.  The pulse is emitted one clock later, lining up with the
  // registered output of slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_start     <= 1'b1;
      period_start <= 1'b0;
    end else begin
      at_start     <= !en || wrap;
      period_start <= en && at_start;
    end
  end

  // shadow==0 never satisfies slot<shadow and shadow==100 always does, so the
  // extremes are constant with no wrap glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_out <= OFF;
    else if (!en)
      pwm_out <= OFF;
    else
      pwm_out <= (slot < shadow) ? ON : OFF;
  end

  assign duty_active = shadow;

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;

  localparam int P   = 4;
  localparam int PER = 100 * P;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [31:0] duty;
  logic               pwm_out;
  logic               period_start;
  logic [6:0]         duty_active;

  int checks   = 0;
  int failures = 0;

  pwm_gen #(.PRESCALE(P), .ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(output bit found);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (period_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Waits two period starts so any shadowed duty is in force.
  task automatic sync_period(input string name);
    bit f1, f2;
    wait_ps(f1);
    wait_ps(f2);
    checks++;
    if (!(f1 && f2)) begin
      failures++;
      $display("FAIL %s period_start timeout: got %0b%0b want 11", name, f1, f2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; duty = 0;
    #12;
    checks++;
    if (pwm_out !== 1'b1 || period_start !== 1'b0 || duty_active !== 7'd0) begin
      failures++;
      $display("FAIL reset_state got pwm=%b ps=%b da=%0d want 1 0 0", pwm_out, period_start, duty_active);
    end
    step();
    rst_n = 1'b1;
    duty  = 30;
    step();
    checks++;
    if (duty_active !== 7'd30 || pwm_out !== 1'b1 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL en_low_load got da=%0d pwm=%b ps=%b want 30 1 0", duty_active, pwm_out, period_start);
    end
  endtask

  task automatic test_en_start();
    en = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL en_start_pulse got %b want 1", period_start);
    end
    step();
    checks++;
    if (period_start !== 1'b0) begin
      failures++;
      $display("FAIL en_start_single got %b want 0", period_start);
    end
  endtask

  task automatic test_duty50();
    int errs, extra;
    duty = 50;
    sync_period("duty50");
    errs = 0; extra = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out !== ((i < PER / 2) ? 1'b0 : 1'b1)) errs++;
      if (i > 0 && period_start === 1'b1) extra++;
      step();
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL duty50_shape got %0d bad clks want 0", errs);
    end
    checks++;
    if (extra != 0 || period_start !== 1'b1) begin
      failures++;
      $display("FAIL duty50_period got extra=%0d ps@400=%b want 0 1", extra, period_start);
    end
  endtask

  task automatic test_clamp();
    int errs;
    duty = 0;
    sync_period("duty0");
    errs = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      if (pwm_out !== 1'b1) errs++;
      step();
    end
    checks++;
    if (errs != 0 || duty_active !== 7'd0) begin
      failures++;
      $display("FAIL duty0 got bad=%0d da=%0d want 0 0", errs, duty_active);
    end

    duty = 100;
    sync_period("duty100");
    errs = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      if (pwm_out !== 1'b0) errs++;
      step();
    end
    checks++;
    if (errs != 0 || duty_active !== 7'd100) begin
      failures++;
      $display("FAIL duty100 got bad=%0d da=%0d want 0 100", errs, duty_active);
    end

    duty = 150;
    sync_period("duty150");
    errs = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out !== 1'b0) errs++;
      step();
    end
    checks++;
    if (duty_active !== 7'd100 || errs != 0) begin
      failures++;
      $display("FAIL duty150_clamp got da=%0d bad=%0d want 100 0", duty_active, errs);
    end

    duty = -5;
    sync_period("dutyneg");
    errs = 0;
    for (int i = 0; i < PER; i++) begin
      if (pwm_out !== 1'b1) errs++;
      step();
    end
    checks++;
    if (duty_active !== 7'd0 || errs != 0) begin
      failures++;
      $display("FAIL dutyneg_clamp got da=%0d bad=%0d want 0 0", duty_active, errs);
    end
  endtask

  task automatic test_duty_change();
    int act1, act2, chg;
    bit p201, p202;
    duty = 30;
    sync_period("change");
    act1 = 0; act2 = 0; p201 = 1'bx; p202 = 1'bx;
`ifdef PWM_SHADOW_EN
    chg = 40;   // slot 10
`else
    chg = 200;  // slot 50, where 30 % is already off
`endif
    for (int i = 0; i < PER; i++) begin
      if (pwm_out === 1'b0) act1++;
      if (i == 201) p201 = pwm_out;
      if (i == 202) p202 = pwm_out;
      if (i == chg) duty = 70;
      step();
    end
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL change_ps got %b want 1", period_start);
    end
    for (int i = 0; i < PER; i++) begin
      if (pwm_out === 1'b0) act2++;
      step();
    end
`ifdef PWM_SHADOW_EN
    checks++;
    if (act1 != 120) begin
      failures++;
      $display("FAIL shadow_cur_period got %0d active want 120", act1);
    end
`else
    checks++;
    if (act1 != 198 || p201 !== 1'b1 || p202 !== 1'b0) begin
      failures++;
      $display("FAIL immediate_change got act=%0d p201=%b p202=%b want 198 1 0", act1, p201, p202);
    end
`endif
    checks++;
    if (act2 != 280) begin
      failures++;
      $display("FAIL change_next_period got %0d active want 280", act2);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    duty = 50;
    sync_period("rstmid");
    for (int i = 0; i < 42 * P; i++) step();
    checks++;
    if (pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre got %b want 0", pwm_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 1'b1 || duty_active !== 7'd0 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async got pwm=%b da=%0d ps=%b want 1 0 0", pwm_out, duty_active, period_start);
    end
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_first_ps got %b want 1", period_start);
    end
    extra = 0;
    for (int i = 1; i < PER; i++) begin
      step();
      if (period_start === 1'b1) extra++;
    end
    step();
    checks++;
    if (extra != 0 || period_start !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_next_ps got extra=%0d ps@400=%b want 0 1", extra, period_start);
    end
  endtask

  task automatic test_en_drop();
    int errs;
    duty = 50;
    sync_period("endrop");
    for (int i = 0; i < 25 * P; i++) step();
    en = 1'b0;
    errs = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      if (pwm_out !== 1'b1 || period_start !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL endrop_hold got %0d bad clks want 0", errs);
    end
    en = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL endrop_restart got ps=%b pwm=%b want 1 0", period_start, pwm_out);
    end
    step();
    checks++;
    if (period_start !== 1'b0 || duty_active !== 7'd50) begin
      failures++;
      $display("FAIL endrop_after got ps=%b da=%0d want 0 50", period_start, duty_active);
    end
  endtask

  initial begin
    test_reset();
    test_en_start();
    test_duty50();
    test_clamp();
    test_duty_change();
    test_reset_mid();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 120, meaning clk cycles per duty slot (12 MHz / 120 / 100 slots = 1 kHz PWM); legal range 1..65535.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning pwm_out is driven low when the LED is on.
REQ-003 SHALL have port clk  input  1  system clock; all logic is in this single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  run enable, synchronous to clk.
REQ-006 SHALL have port duty  input  32 (signed int)  requested duty in percent; this is the ramp block's pwm_value.
REQ-007 SHALL have port pwm_out  output  1  registered LED drive.
REQ-008 SHALL have port period_start  output  1  registered one-clk pulse marking the start of a PWM period.
REQ-009 SHALL have port duty_active  output  7  shadow duty (0..100) currently being applied.

Function
REQ-010 SHALL keep prescaler pre_cnt counting 0..PRESCALE-1; tick is defined as pre_cnt==PRESCALE-1.
REQ-011 SHALL advance slot counter slot 0..99 on each tick, wrapping 99->0.
REQ-012 SHALL clamp duty as follows: below 0 -> 0; above 100 -> 100; otherwise pass through unchanged.
REQ-013 SHALL load the clamped duty into the shadow register only on the clk where tick and slot==99 are both true, so the new value takes effect from slot 0.
REQ-014 SHALL register pwm_out as active when slot < shadow and inactive otherwise; pwm_out lags the slot counter by one clk.
REQ-015 SHALL yield an active time per period of exactly shadow*PRESCALE clks out of 100*PRESCALE clks.
REQ-016 SHALL keep pwm_out constantly inactive when shadow==0 and constantly active when shadow==100, with no glitch at the wrap.
REQ-017 SHALL define "active" as 0 and "inactive" as 1 when ACTIVE_LOW=1, and the opposite when ACTIVE_LOW=0.
REQ-018 SHALL assert period_start for exactly one clk in the cycle after the counters wrap from (99, PRESCALE-1) to (0, 0).
REQ-019 SHALL, while en is low, synchronously hold pre_cnt=0 and slot=0, drive pwm_out inactive, hold period_start=0, and load the clamped duty into the shadow every clk.
REQ-020 SHALL, on the first clk with en high after en was low, start a period from slot 0 and assert period_start in the following clk.
REQ-021 SHALL, if en falls on the same clk as a shadow-load point, apply the en-low behaviour and still perform the load.
REQ-022 SHALL drive duty_active equal to the shadow register at all times.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force pre_cnt=0, slot=0, shadow=0, duty_active=0, period_start=0, and pwm_out inactive (1 if ACTIVE_LOW).
REQ-024 SHALL, on the first rising clk edge after rst_n goes high with en high, behave as described in REQ-020.

Configuration
REQ-025 SHALL, when PWM_SHADOW_EN is defined, update the shadow only per REQ-013 (glitch-free, period-aligned updates).
REQ-026 SHALL, when PWM_SHADOW_EN is undefined, load the shadow with the clamped duty every clk, so a duty change affects pwm_out two clks later, mid-period allowed.

Structure
REQ-027 SHALL place DUTY_MAX=100, N_SLOTS=100, typedef duty_t (7-bit unsigned), and the clamp function in package pwm_pkg.
REQ-028 SHALL implement the prescaler as sub-module pwm_tick_gen, with inputs clk, rst_n and clear, and output tick.

Verification
REQ-029 SHALL verify, with PRESCALE=4 and duty=50 held: each 400-clk period shows 200 clks active followed by 200 clks inactive, and period_start pulses every 400 clks.
REQ-030 SHALL verify that duty=0 gives pwm_out inactive for 3 full periods, duty=100 gives pwm_out active for 3 full periods, and duty=150 gives duty_active=100.
REQ-031 SHALL verify that duty=-5 gives duty_active=0 and pwm_out constantly inactive.
REQ-032 SHALL verify, with PWM_SHADOW_EN defined, that a duty change 30->70 at slot 10 leaves the current period at 30% and makes the next period, starting at period_start, 70%.
REQ-033 SHALL verify that asserting rst_n low at slot 42 immediately gives pwm_out inactive and duty_active=0, and that after release the first period_start arrives at the expected clk.
REQ-034 SHALL verify that dropping en for 17 clks mid-period forces pwm_out inactive during the drop, and that after en re-rises the period restarts with period_start one clk later.
